// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encodings, mode constants and the SS polarity helper.
// Used by both the slave and master drivers.
package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RESET  = 2'd2
  } spi_state_e;

  // Mode 0: SCLK idles low, data sampled on the leading edge
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

  function automatic logic ss_active(input logic level, input logic active_low);
    return active_low ? ~level : level;
  endfunction

endpackage

// File: rtl/sync_edge_detector.sv
// Multi-stage input synchroniser followed by one history flop for edge detection.
// Reset loads every stage with RESET_LEVEL so no spurious edge appears after reset.
module sync_edge_detector #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RESET_LEVEL}};
      prev_q <= RESET_LEVEL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_driver.sv
// SPI mode-0 slave physical layer: oversampled SS/SCLK/MOSI, word deserialiser for MOSI
// and word serialiser for MISO, with back-to-back words inside one SS assertion.
module spi_slave_driver
  import spi_pkg::*;
#(
  parameter bit SS_ACTIVE_LOW = 1'b1,
  parameter bit LSB_FIRST     = 1'b0,
  parameter int NUM_DATA_BITS = 8,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     sys_clk,
  input  logic                     rst_n,
  input  logic [NUM_DATA_BITS-1:0] miso_data,
  output logic                     miso_load,
  output logic [NUM_DATA_BITS-1:0] mosi_data,
  output logic                     mosi_new_data,
  output logic                     frame_active,
  output logic                     frame_error,
  input  logic                     ss_in,
  input  logic                     sclk_in,
  input  logic                     mosi_in,
  output logic                     miso_out,
  output logic                     miso_oe
);

  localparam int                CNT_W          = $clog2(NUM_DATA_BITS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST       = CNT_W'(NUM_DATA_BITS - 1);
  localparam logic              SS_IDLE_LEVEL  = SS_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam bit                SAMPLE_ON_RISE = (SPI_CPOL == SPI_CPHA);

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl_unused, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  sync_edge_detector #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(SS_IDLE_LEVEL)) u_ss_sync (
    .sys_clk(sys_clk), .rst_n(rst_n), .async_in(ss_in),
    .level(ss_lvl), .rise(ss_rise), .fall(ss_fall)
  );

  sync_edge_detector #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(SPI_CPOL)) u_sclk_sync (
    .sys_clk(sys_clk), .rst_n(rst_n), .async_in(sclk_in),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge_detector #(.SYNC_STAGES(SYNC_STAGES), .RESET_LEVEL(1'b0)) u_mosi_sync (
    .sys_clk(sys_clk), .rst_n(rst_n), .async_in(mosi_in),
    .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic ss_assert_edge, ss_deassert_edge, sample_edge, shift_edge;

  assign ss_assert_edge   = SS_ACTIVE_LOW ? ss_fall : ss_rise;
  assign ss_deassert_edge = SS_ACTIVE_LOW ? ss_rise : ss_fall;
  assign sample_edge      = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
  assign shift_edge       = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;

  function automatic logic first_bit(input logic [NUM_DATA_BITS-1:0] w);
    return LSB_FIRST ? w[0] : w[NUM_DATA_BITS-1];
  endfunction

  spi_state_e               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_DATA_BITS-1:0] rx_q, rx_d;
  logic [NUM_DATA_BITS-1:0] tx_q, tx_d;
  logic [NUM_DATA_BITS-1:0] mosi_data_q, mosi_data_d;
  logic                     first_q, first_d;
  logic                     miso_load_q, miso_load_d;
  logic                     mosi_new_q, mosi_new_d;
  logic                     frame_err_q, frame_err_d;
  logic                     miso_oe_q, miso_oe_d;
  logic                     miso_out_q, miso_out_d;

  logic [NUM_DATA_BITS-1:0] rx_shifted, tx_shifted;

  always_comb begin
    rx_shifted = LSB_FIRST ? {mosi_lvl, rx_q[NUM_DATA_BITS-1:1]}
                           : {rx_q[NUM_DATA_BITS-2:0], mosi_lvl};
    tx_shifted = LSB_FIRST ? (tx_q >> 1) : (tx_q << 1);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    mosi_data_d = mosi_data_q;
    first_d     = first_q;
    miso_load_d = 1'b0;
    mosi_new_d  = 1'b0;
    frame_err_d = 1'b0;
    miso_oe_d   = miso_oe_q;
    miso_out_d  = miso_out_q;

    case (state_q)
      ST_ACTIVE: begin
        // SS deassert takes priority over any coincident SCLK edge
        if (ss_deassert_edge) begin
          state_d     = ST_IDLE;
          miso_oe_d   = 1'b0;
          miso_out_d  = 1'b0;
          frame_err_d = (cnt_q != '0);
          cnt_d       = '0;
          first_d     = 1'b0;
        end else if (sample_edge) begin
          rx_d    = rx_shifted;
          first_d = 1'b0;
          if (cnt_q == CNT_LAST) begin
            mosi_data_d = rx_shifted;
            mosi_new_d  = 1'b1;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (shift_edge) begin
          if (cnt_q != '0) begin
            tx_d       = tx_shifted;
            miso_out_d = first_bit(tx_shifted);
          end else if (!first_q) begin
            // Word boundary: fetch the next word from upstream
            tx_d        = miso_data;
            miso_load_d = 1'b1;
            miso_out_d  = first_bit(miso_data);
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        miso_oe_d  = 1'b0;
        miso_out_d = 1'b0;
        if (ss_assert_edge) begin
          state_d     = ST_ACTIVE;
          tx_d        = miso_data;
          miso_load_d = 1'b1;
          miso_oe_d   = 1'b1;
          miso_out_d  = first_bit(miso_data);
          cnt_d       = '0;
          first_d     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      mosi_data_q <= '0;
      first_q     <= 1'b0;
      miso_load_q <= 1'b0;
      mosi_new_q  <= 1'b0;
      frame_err_q <= 1'b0;
      miso_oe_q   <= 1'b0;
      miso_out_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      mosi_data_q <= mosi_data_d;
      first_q     <= first_d;
      miso_load_q <= miso_load_d;
      mosi_new_q  <= mosi_new_d;
      frame_err_q <= frame_err_d;
      miso_oe_q   <= miso_oe_d;
      miso_out_q  <= miso_out_d;
    end
  end

  assign miso_load     = miso_load_q;
  assign mosi_data     = mosi_data_q;
  assign mosi_new_data = mosi_new_q;
  assign frame_error   = frame_err_q;
  assign miso_oe       = miso_oe_q;
  assign miso_out      = miso_out_q;
  assign frame_active  = ss_active(ss_lvl, SS_ACTIVE_LOW);

endmodule
